// File: rtl/ula_sequenciador.sv
// ula_sequenciador -- command front-end for the 8-bit ULA.
//
// Commands {opCode, A, B, usaAcumulador} are accepted on a valid/ready
// handshake and queued in a FIFO. A three-state FSM (OCIOSO, AGUARDA and
// ENTREGA) issues one command at a time to the ULA operand registers. It
// waits LATENCIA_ULA edges, captures the 9-bit result, and presents it on
// a second valid/ready handshake. The accumulator keeps the last result,
// so a command can use it in place of operand A.
//
// Parameters:
//   PROFUNDIDADE  FIFO depth in commands (power of 2, >= 2)
//   LATENCIA_ULA  edges from operands stable to ula_saida9Bits valid
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   cmd_*                    command input handshake and payload
//   ula_entradaA8Bits/B/op   registered operands to the ULA
//   ula_saida9Bits           result from the ULA
//   res_*                    result output handshake and payload
//   ocupado                  FIFO non-empty or FSM not idle
//
// Optional feature (macro ULA_SEQ_OPCODE_INVALIDO_EN):
//   When the macro is defined, opcodes 4'b1100-4'b1111 are rejected without
//   touching the ULA. They are answered directly with res_erro = 1 and a
//   zero result. When the macro is undefined, res_erro is tied to 0.
module ula_sequenciador #(
   parameter int PROFUNDIDADE = 4,
   parameter int LATENCIA_ULA = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_opCode,
   input  logic [7:0] cmd_entradaA,
   input  logic [7:0] cmd_entradaB,
   input  logic       cmd_usaAcumulador,
   output logic [7:0] ula_entradaA8Bits,
   output logic [7:0] ula_entradaB8Bits,
   output logic [3:0] ula_opCode,
   input  logic [8:0] ula_saida9Bits,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [8:0] res_saida9Bits,
   output logic [3:0] res_opCode,
   output logic       res_erro,
   output logic       ocupado
);

   localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
   localparam int CW = PW + 1;
   localparam int TW = (LATENCIA_ULA > 0) ? $clog2(LATENCIA_ULA + 1) : 1;
   localparam int EW = 21;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      AGUARDA = 2'd1,
      ENTREGA = 2'd2
   } estado_t;

   estado_t       estado_r, estado_prox_s;

   logic [EW-1:0] mem_r [PROFUNDIDADE];
   logic [PW-1:0] wr_ptr_r, rd_ptr_r;
   logic [CW-1:0] cont_fifo_r;
   logic          cheia_s, vazia_s, push_s, pop_s;
   logic          invalido_s, emite_s, rejeita_s, captura_s;
   logic [3:0]    cab_op_s;
   logic [7:0]    cab_a_s, cab_b_s;
   logic          cab_usa_s;
   logic [TW-1:0] contador_r;
   // Only the low byte is ever fed back, so bit 8 of the result is not kept.
   logic [7:0]    acumulador_r;
   logic [7:0]    ula_a_r, ula_b_r;
   logic [3:0]    ula_op_r;
   logic [8:0]    res_saida_r;
   logic [3:0]    res_op_r;
   logic          res_valid_s, ocupado_s;

   // A full FIFO refuses the push even when a pop happens in the same cycle.
   assign cheia_s   = (cont_fifo_r == CW'(PROFUNDIDADE));
   assign vazia_s   = (cont_fifo_r == {CW{1'b0}});
   assign cmd_ready = !cheia_s && !reset;
   assign push_s    = cmd_valid && cmd_ready;
   assign pop_s     = (estado_r == OCIOSO) && !vazia_s;
   assign {cab_op_s, cab_a_s, cab_b_s, cab_usa_s} = mem_r[rd_ptr_r];

`ifdef ULA_SEQ_OPCODE_INVALIDO_EN
   function automatic logic opcode_invalido(input logic [3:0] op);
      return (op[3] && op[2]);
   endfunction
   assign invalido_s = opcode_invalido(cab_op_s);
`else
   assign invalido_s = 1'b0;
`endif

   assign emite_s   = pop_s && !invalido_s;
   assign rejeita_s = pop_s && invalido_s;
   assign captura_s = (estado_r == AGUARDA) && (contador_r == {TW{1'b0}});

   // FIFO storage write (contents need no reset, the count guards reads)
   always_ff @(posedge clock) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {cmd_opCode, cmd_entradaA, cmd_entradaB, cmd_usaAcumulador};
      end
   end

   // FIFO pointers and occupancy count
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         cont_fifo_r <= {CW{1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
         cont_fifo_r <= cont_fifo_r + CW'(push_s) - CW'(pop_s);
      end
   end

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) estado_r <= OCIOSO;
      else       estado_r <= estado_prox_s;
   end

   // FSM next-state logic
   always_comb begin
      estado_prox_s = estado_r;
      case (estado_r)
         OCIOSO: begin
            if (!vazia_s) begin
               if (invalido_s) estado_prox_s = ENTREGA;
               else            estado_prox_s = AGUARDA;
            end else begin
               estado_prox_s = OCIOSO;
            end
         end
         AGUARDA: begin
            if (contador_r == {TW{1'b0}}) estado_prox_s = ENTREGA;
            else                          estado_prox_s = AGUARDA;
         end
         ENTREGA: begin
            if (res_ready) estado_prox_s = OCIOSO;
            else           estado_prox_s = ENTREGA;
         end
         default: estado_prox_s = OCIOSO;
      endcase
   end

   // FSM outputs derived from registered state only
   always_comb begin
      res_valid_s = 1'b0;
      case (estado_r)
         ENTREGA: res_valid_s = 1'b1;
         default: res_valid_s = 1'b0;
      endcase
      ocupado_s = !vazia_s || (estado_r != OCIOSO);
   end

   // ULA operand registers, loaded at issue and held between commands
   always_ff @(posedge clock) begin
      if (reset) begin
         ula_a_r  <= 8'd0;
         ula_b_r  <= 8'd0;
         ula_op_r <= 4'd0;
      end else if (emite_s) begin
         ula_a_r  <= cab_usa_s ? acumulador_r : cab_a_s;
         ula_b_r  <= cab_b_s;
         ula_op_r <= cab_op_s;
      end
   end

   // Latency countdown while waiting for the ULA
   always_ff @(posedge clock) begin
      if (reset) begin
         contador_r <= {TW{1'b0}};
      end else if (emite_s) begin
         contador_r <= TW'(LATENCIA_ULA);
      end else if ((estado_r == AGUARDA) && (contador_r != {TW{1'b0}})) begin
         contador_r <= contador_r - TW'(1);
      end
   end

   // Result and accumulator capture
   always_ff @(posedge clock) begin
      if (reset) begin
         res_saida_r  <= 9'd0;
         res_op_r     <= 4'd0;
         acumulador_r <= 8'd0;
      end else if (captura_s) begin
         res_saida_r  <= ula_saida9Bits;
         res_op_r     <= ula_op_r;
         acumulador_r <= ula_saida9Bits[7:0];
      end else if (rejeita_s) begin
         res_saida_r  <= 9'd0;
         res_op_r     <= cab_op_s;
      end
   end

`ifdef ULA_SEQ_OPCODE_INVALIDO_EN
   logic res_erro_r;

   // Error flag: set by a rejected opcode, cleared by a real capture
   always_ff @(posedge clock) begin
      if (reset)          res_erro_r <= 1'b0;
      else if (captura_s) res_erro_r <= 1'b0;
      else if (rejeita_s) res_erro_r <= 1'b1;
   end

   assign res_erro = res_erro_r;
`else
   assign res_erro = 1'b0;
`endif

   assign ula_entradaA8Bits = ula_a_r;
   assign ula_entradaB8Bits = ula_b_r;
   assign ula_opCode        = ula_op_r;
   assign res_saida9Bits    = res_saida_r;
   assign res_opCode        = res_op_r;
   assign res_valid         = res_valid_s;
   assign ocupado           = ocupado_s;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed testbench for ula_sequenciador with the default parameters.
// A one-edge registered ULA model (add, sub, and, xor) drives
// ula_saida9Bits.
module tb_ula_sequenciador;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_opCode = 4'd0;
   logic [7:0] cmd_entradaA = 8'd0;
   logic [7:0] cmd_entradaB = 8'd0;
   logic       cmd_usaAcumulador = 1'b0;
   logic [7:0] ula_entradaA8Bits;
   logic [7:0] ula_entradaB8Bits;
   logic [3:0] ula_opCode;
   logic [8:0] ula_saida9Bits = 9'd0;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [8:0] res_saida9Bits;
   logic [3:0] res_opCode;
   logic       res_erro;
   logic       ocupado;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   ula_sequenciador dut (
      .clock             (clock),
      .reset             (reset),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_opCode        (cmd_opCode),
      .cmd_entradaA      (cmd_entradaA),
      .cmd_entradaB      (cmd_entradaB),
      .cmd_usaAcumulador (cmd_usaAcumulador),
      .ula_entradaA8Bits (ula_entradaA8Bits),
      .ula_entradaB8Bits (ula_entradaB8Bits),
      .ula_opCode        (ula_opCode),
      .ula_saida9Bits    (ula_saida9Bits),
      .res_valid         (res_valid),
      .res_ready         (res_ready),
      .res_saida9Bits    (res_saida9Bits),
      .res_opCode        (res_opCode),
      .res_erro          (res_erro),
      .ocupado           (ocupado)
   );

   // ULA model with one edge of latency
   always @(posedge clock) begin
      case (ula_opCode)
         4'd0:    ula_saida9Bits <= {1'b0, ula_entradaA8Bits} + {1'b0, ula_entradaB8Bits};
         4'd1:    ula_saida9Bits <= {1'b0, ula_entradaA8Bits} - {1'b0, ula_entradaB8Bits};
         4'd2:    ula_saida9Bits <= {1'b0, ula_entradaA8Bits & ula_entradaB8Bits};
         default: ula_saida9Bits <= {1'b0, ula_entradaA8Bits ^ ula_entradaB8Bits};
      endcase
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present one command until accepted; returns #1 after the accepting edge.
   task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic usa, output logic ok);
      logic rdy;
      int   t;
      ok = 1'b0;
      t  = 0;
      cmd_valid = 1'b1;
      cmd_opCode = op;
      cmd_entradaA = a;
      cmd_entradaB = b;
      cmd_usaAcumulador = usa;
      while (!ok && t < 50) begin
         rdy = cmd_ready;
         tick();
         if (rdy) ok = 1'b1;
         t++;
      end
      cmd_valid = 1'b0;
   endtask

   // Advance until res_valid is seen (bounded).
   task automatic wait_res(input int max, output logic ok);
      int n;
      n = 0;
      while (res_valid !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      ok = (res_valid === 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cmd_valid = 1'b1;
      tick();
      tick();
      n_tests++;
      if (cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready);
      end
      n_tests++;
      if ({res_valid, res_saida9Bits, res_opCode, res_erro, ocupado} !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_res: got v=%b r=%0d op=%0d e=%b oc=%b expected all 0",
                  res_valid, res_saida9Bits, res_opCode, res_erro, ocupado);
      end
      n_tests++;
      if ({ula_entradaA8Bits, ula_entradaB8Bits, ula_opCode} !== 20'd0) begin
         n_fail++;
         $display("FAIL reset_ula: got a=%0d b=%0d op=%0d expected 0",
                  ula_entradaA8Bits, ula_entradaB8Bits, ula_opCode);
      end
      cmd_valid = 1'b0;
      reset = 1'b0;
      #1;
      n_tests++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_cmd_ready: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_addition();
      logic ok;
      res_ready = 1'b1;
      push(4'd0, 8'd9, 8'd20, 1'b0, ok);
      n_tests++;
      if (ok !== 1'b1 || res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_push_E: got ok=%b valid=%b expected ok=1 valid=0", ok, res_valid);
      end
      tick();
      n_tests++;
      if (ula_entradaA8Bits !== 8'd9 || ula_entradaB8Bits !== 8'd20 || ula_opCode !== 4'd0 ||
          res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_issue_E1: got a=%0d b=%0d op=%0d v=%b expected 9 20 0 0",
                  ula_entradaA8Bits, ula_entradaB8Bits, ula_opCode, res_valid);
      end
      tick();
      n_tests++;
      if (res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_valid_E2: got %b expected 0", res_valid);
      end
      tick();
      n_tests++;
      if (res_valid !== 1'b1 || res_saida9Bits !== 9'd29 || res_erro !== 1'b0 ||
          res_opCode !== 4'd0) begin
         n_fail++;
         $display("FAIL add_result_E3: got v=%b r=%0d e=%b op=%0d expected 1 29 0 0",
                  res_valid, res_saida9Bits, res_erro, res_opCode);
      end
      tick();
      n_tests++;
      if (res_valid !== 1'b0 || ocupado !== 1'b0) begin
         n_fail++;
         $display("FAIL add_done_E4: got v=%b oc=%b expected 0 0", res_valid, ocupado);
      end
   endtask

   task automatic test_overflow();
      logic ok, okr;
      res_ready = 1'b1;
      push(4'd0, 8'd255, 8'd255, 1'b0, ok);
      wait_res(10, okr);
      n_tests++;
      if (!ok || !okr || res_saida9Bits !== 9'h1FE) begin
         n_fail++;
         $display("FAIL overflow: got ok=%b valid=%b r=%0d expected 510", ok, okr, res_saida9Bits);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic ok1, ok2, okr;
      int   n;
      res_ready = 1'b1;
      push(4'd0, 8'd9, 8'd20, 1'b0, ok1);
      push(4'd0, 8'd200, 8'd1, 1'b1, ok2);
      wait_res(10, okr);
      n_tests++;
      if (!ok1 || !ok2 || !okr || res_saida9Bits !== 9'd29) begin
         n_fail++;
         $display("FAIL chain_first: got ok=%b%b%b r=%0d expected 29", ok1, ok2, okr,
                  res_saida9Bits);
      end
      tick();
      n = 1;
      while (res_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      n_tests++;
      if (res_valid !== 1'b1 || res_saida9Bits !== 9'd30 || ula_entradaA8Bits !== 8'd29) begin
         n_fail++;
         $display("FAIL chain_second: got v=%b r=%0d a=%0d expected 1 30 29",
                  res_valid, res_saida9Bits, ula_entradaA8Bits);
      end
      n_tests++;
      if (n !== 4) begin
         n_fail++;
         $display("FAIL back_to_back_spacing: got %0d cycles expected 4", n);
      end
      tick();
   endtask

   task automatic test_full();
      logic [3:0] ops [6];
      logic [7:0] as  [6];
      logic [7:0] bs  [6];
      logic [8:0] exp [5];
      logic       last_rdy, okr, stable;
      int         idx;
      ops = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      as  = '{8'd1, 8'd10, 8'd50, 8'hF0, 8'hAA, 8'd1};
      bs  = '{8'd2, 8'd20, 8'd8, 8'h3C, 8'h55, 8'd1};
      exp = '{9'd3, 9'd30, 9'd42, 9'd48, 9'd255};
      res_ready = 1'b0;
      idx = 0;
      last_rdy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cmd_valid = 1'b1;
         cmd_opCode = ops[idx];
         cmd_entradaA = as[idx];
         cmd_entradaB = bs[idx];
         cmd_usaAcumulador = 1'b0;
         last_rdy = cmd_ready;
         tick();
         if (last_rdy) idx++;
      end
      cmd_valid = 1'b0;
      n_tests++;
      if (idx !== 5 || last_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL full_accept: got accepted=%0d ready6=%b expected 5 0", idx, last_rdy);
      end
      wait_res(20, okr);
      stable = okr;
      for (int i = 0; i < 5; i++) begin
         if (res_valid !== 1'b1 || res_saida9Bits !== 9'd3 || res_opCode !== 4'd0 ||
             cmd_ready !== 1'b0)
            stable = 1'b0;
         tick();
      end
      n_tests++;
      if (stable !== 1'b1) begin
         n_fail++;
         $display("FAIL full_hold: got v=%b r=%0d rdy=%b expected stable 1 3 0",
                  res_valid, res_saida9Bits, cmd_ready);
      end
      res_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_res(20, okr);
         n_tests++;
         if (!okr || res_saida9Bits !== exp[k] || res_opCode !== ops[k]) begin
            n_fail++;
            $display("FAIL full_order[%0d]: got v=%b r=%0d op=%0d expected %0d op=%0d",
                     k, okr, res_saida9Bits, res_opCode, exp[k], ops[k]);
         end
         tick();
      end
      n_tests++;
      if (ocupado !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL full_drained: got oc=%b rdy=%b expected 0 1", ocupado, cmd_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic ok1, ok2, ok3, okr, quiet;
      res_ready = 1'b1;
      push(4'd0, 8'd1, 8'd1, 1'b0, ok1);
      push(4'd0, 8'd2, 8'd2, 1'b0, ok2);
      push(4'd0, 8'd3, 8'd3, 1'b0, ok3);
      n_tests++;
      if (!ok1 || !ok2 || !ok3 || ocupado !== 1'b1 || res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_setup: got ok=%b%b%b oc=%b v=%b expected 111 1 0",
                  ok1, ok2, ok3, ocupado, res_valid);
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if (cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_ready: got %b expected 0", cmd_ready);
      end
      tick();
      n_tests++;
      if ({res_valid, res_saida9Bits, res_opCode, res_erro, ocupado} !== 16'd0 ||
          {ula_entradaA8Bits, ula_entradaB8Bits, ula_opCode} !== 20'd0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got v=%b r=%0d oc=%b a=%0d b=%0d expected all 0",
                  res_valid, res_saida9Bits, ocupado, ula_entradaA8Bits, ula_entradaB8Bits);
      end
      reset = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (res_valid !== 1'b0 || ocupado !== 1'b0) quiet = 1'b0;
      end
      n_tests++;
      if (quiet !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_quiet: got activity after reset expected none");
      end
      // Accumulator was cleared, so 0 + 5 is expected.
      push(4'd0, 8'd77, 8'd5, 1'b1, ok1);
      wait_res(10, okr);
      n_tests++;
      if (!ok1 || !okr || res_saida9Bits !== 9'd5 || ula_entradaA8Bits !== 8'd0) begin
         n_fail++;
         $display("FAIL mid_reset_acc: got r=%0d a=%0d expected 5 0",
                  res_saida9Bits, ula_entradaA8Bits);
      end
      tick();
   endtask

`ifdef ULA_SEQ_OPCODE_INVALIDO_EN
   task automatic test_invalid_opcode();
      logic ok, okr;
      res_ready = 1'b1;
      push(4'd0, 8'd9, 8'd20, 1'b0, ok);
      wait_res(10, okr);
      tick();
      push(4'b1101, 8'd1, 8'd2, 1'b0, ok);
      n_tests++;
      if (!ok || res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL inv_push: got ok=%b v=%b expected 1 0", ok, res_valid);
      end
      tick();
      n_tests++;
      if (res_valid !== 1'b1 || res_erro !== 1'b1 || res_saida9Bits !== 9'd0 ||
          res_opCode !== 4'b1101 || ula_opCode !== 4'd0 || ula_entradaA8Bits !== 8'd9) begin
         n_fail++;
         $display("FAIL inv_result: got v=%b e=%b r=%0d op=%0d ula_op=%0d a=%0d expected 1 1 0 13 0 9",
                  res_valid, res_erro, res_saida9Bits, res_opCode, ula_opCode, ula_entradaA8Bits);
      end
      tick();
      push(4'd0, 8'd0, 8'd1, 1'b1, ok);
      wait_res(10, okr);
      n_tests++;
      if (!okr || res_saida9Bits !== 9'd30 || res_erro !== 1'b0) begin
         n_fail++;
         $display("FAIL inv_acc_kept: got r=%0d e=%b expected 30 0", res_saida9Bits, res_erro);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_addition();
      test_overflow();
      test_back_to_back();
      test_full();
      test_reset_mid();
`ifdef ULA_SEQ_OPCODE_INVALIDO_EN
      test_invalid_opcode();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
